countdown_timer: RTL and testbench

- Loadable binary down-counter with a start/pause/done handshake; the counterpart to the team's free-running 4-bit up-counter.
- The up-counter measures elapsed cycles. This block is preset with a cycle count and signals when that count has expired.
- Used as a delay/timeout generator by control FSMs elsewhere in the design.

---
 rtl/countdown_timer_if.sv | 23 ++
 rtl/countdown_timer.sv | 93 +++++++++
 tb/tb_countdown_timer.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/countdown_timer_if.sv
// Control/status bundle for countdown_timer.
// The master (a control FSM) drives the strobes. The slave (the timer) returns the count and status.
interface countdown_timer_if #(
  parameter int WIDTH = 4
);
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             start;
  logic             pause;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;

  modport master (
    output load, load_val, start, pause,
    input  count, busy, done
  );

  modport slave (
    input  load, load_val, start, pause,
    output count, busy, done
  );
endinterface

// File: rtl/countdown_timer.sv
// Loadable down-counter with start/pause handshake and a one-cycle done pulse.
// When AUTO_RELOAD=1, the timer reloads the last preset at expiry and keeps running.
module countdown_timer #(
  parameter int WIDTH       = 4,
  parameter bit AUTO_RELOAD = 1'b0
) (
  input logic                clk,
  input logic                rst,
  countdown_timer_if.slave   bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSED = 2'd2} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] eff_val;

  // In IDLE, load and start in the same cycle start from the new preset.
  assign eff_val = bus.load ? bus.load_val : count_q;

  // Next-state decode. Priority in RUN is load > pause > decrement.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.load) begin
          count_d  = bus.load_val;
          reload_d = bus.load_val;
        end
        if (bus.start) begin
          if (eff_val != '0) state_d = RUN;
          else               done_d  = 1'b1;   // a zero preset expires immediately
        end
      end
      RUN: begin
        if (bus.load) begin
          count_d  = bus.load_val;
          reload_d = bus.load_val;
          state_d  = IDLE;
        end else if (bus.pause) begin
          state_d = PAUSED;
        end else if (count_q == WIDTH'(1)) begin
          done_d = 1'b1;
          if (AUTO_RELOAD && reload_q != '0) begin
            count_d = reload_q;
          end else begin
            count_d = '0;
            state_d = IDLE;
          end
        end else if (count_q == '0) begin
          state_d = IDLE;                     // defensive: zero is terminal, never wrap
        end else begin
          count_d = count_q - WIDTH'(1);
        end
      end
      PAUSED: begin
        if (bus.load) begin
          count_d  = bus.load_val;
          reload_d = bus.load_val;
          state_d  = IDLE;
        end else if (!bus.pause) begin
          state_d = RUN;                      // resume edge does not decrement
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, count, reload and done registers. Reset clears everything without raising done.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      done_q   <= done_d;
    end
  end

  assign bus.count = count_q;
  assign bus.busy  = (state_q == RUN) || (state_q == PAUSED);
  assign bus.done  = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Randomised and directed check of countdown_timer in one-shot and auto-reload variants.
// Both instances share the same stimulus and are compared against an abstract timer model.
module tb_countdown_timer;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       load = 1'b0, start = 1'b0, pause = 1'b0;
  logic [3:0] lv = '0;

  int total = 0;
  int bad   = 0;

  countdown_timer_if #(.WIDTH(4)) b0 ();
  countdown_timer_if #(.WIDTH(4)) b1 ();

  assign b0.load = load;  assign b0.load_val = lv;  assign b0.start = start;  assign b0.pause = pause;
  assign b1.load = load;  assign b1.load_val = lv;  assign b1.start = start;  assign b1.pause = pause;

  countdown_timer #(.WIDTH(4), .AUTO_RELOAD(1'b0)) u_one (.clk(clk), .rst(rst), .bus(b0));
  countdown_timer #(.WIDTH(4), .AUTO_RELOAD(1'b1)) u_rel (.clk(clk), .rst(rst), .bus(b1));

  always #5 clk = ~clk;

  // Reference model: timer remaining cycles plus flags, per instance (index = AUTO_RELOAD)
  int m_cnt [2];
  int m_rel [2];
  bit m_run [2];
  bit m_hold[2];
  bit m_done[2];

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < 2; i++) begin
      m_cnt[i] = 0; m_rel[i] = 0; m_run[i] = 0; m_hold[i] = 0; m_done[i] = 0;
    end
  endtask

  // One clock's worth of timer behaviour, from the plain rules
  task automatic m_step(input int i);
    m_done[i] = 0;
    if (!m_run[i]) begin
      if (load) begin m_cnt[i] = lv; m_rel[i] = lv; end
      if (start) begin
        if (m_cnt[i] != 0) begin m_run[i] = 1; m_hold[i] = 0; end
        else m_done[i] = 1;
      end
    end else if (load) begin
      m_cnt[i] = lv; m_rel[i] = lv; m_run[i] = 0; m_hold[i] = 0;
    end else if (m_hold[i]) begin
      if (!pause) m_hold[i] = 0;
    end else if (pause) begin
      m_hold[i] = 1;
    end else begin
      m_cnt[i] = m_cnt[i] - 1;
      if (m_cnt[i] <= 0) begin
        m_done[i] = 1;
        m_cnt[i]  = 0;
        if (i == 1 && m_rel[i] != 0) m_cnt[i] = m_rel[i];
        else m_run[i] = 0;
      end
    end
  endtask

  task automatic check_all();
    chk("cnt0",  int'(b0.count), m_cnt[0]);
    chk("busy0", int'(b0.busy),  int'(m_run[0]));
    chk("done0", int'(b0.done),  int'(m_done[0]));
    chk("cnt1",  int'(b1.count), m_cnt[1]);
    chk("busy1", int'(b1.busy),  int'(m_run[1]));
    chk("done1", int'(b1.done),  int'(m_done[1]));
  endtask

  task automatic drive(input bit l, input int v, input bit s, input bit p);
    load = l; lv = 4'(v); start = s; pause = p;
  endtask

  // Advance one edge, update the model with the inputs the DUT saw, then compare
  task automatic cyc();
    @(posedge clk);
    if (!rst) m_reset();
    else begin m_step(0); m_step(1); end
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    drive(0, 0, 0, 0);
    for (int k = 0; k < n; k++) cyc();
  endtask

  // Pull reset between edges and confirm it acts before the next edge
  task automatic async_reset();
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    m_reset();
    chk("arst_cnt0",  int'(b0.count), 0);
    chk("arst_busy0", int'(b0.busy),  0);
    chk("arst_done0", int'(b0.done),  0);
    chk("arst_cnt1",  int'(b1.count), 0);
    cyc();
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int n;
    m_reset();
    // Reset held with a load pending: nothing moves
    drive(1, 9, 0, 0);
    for (int k = 0; k < 2; k++) begin
      cyc();
      chk("rst_cnt", int'(b0.count), 0);
      chk("rst_busy", int'(b0.busy), 0);
    end
    @(negedge clk); rst = 1'b1; drive(0, 0, 0, 0);
    cyc();
    chk("post_rst_cnt", int'(b0.count), 0);

    // Basic countdown from 5
    drive(1, 5, 0, 0); cyc();
    drive(0, 0, 1, 0); cyc();
    chk("start_cnt", int'(b0.count), 5);
    idle(11);
    chk("end_cnt", int'(b0.count), 0);

    // Pause at 6, then abort with load 3 at 4
    drive(1, 8, 0, 0); cyc();
    drive(0, 0, 1, 0); cyc();
    idle(2);
    drive(0, 0, 0, 1);
    for (int k = 0; k < 3; k++) begin cyc(); chk("pause_hold", int'(b0.count), 6); end
    idle(1);
    chk("resume_no_dec", int'(b0.count), 6);
    n = 0;
    while (m_cnt[0] != 4 && n < 20) begin cyc(); n++; end
    drive(1, 3, 0, 0); cyc();
    chk("abort_cnt", int'(b0.count), 3);
    chk("abort_busy", int'(b0.busy), 0);
    idle(2);

    // Max preset with load+start together: 16 edges to done
    drive(1, 15, 1, 0); cyc();
    drive(0, 0, 0, 0);
    n = 0;
    while (!b0.done && n < 40) begin cyc(); n++; end
    chk("lat15", n + 1, 16);
    drive(1, 0, 0, 0); cyc();

    // Zero preset start: immediate done, no busy
    drive(0, 0, 1, 0); cyc();
    chk("zero_done", int'(b0.done), 1);
    chk("zero_busy", int'(b0.busy), 0);
    idle(2);

    // Asynchronous reset mid-count
    drive(1, 9, 1, 0); cyc();
    drive(0, 0, 0, 0);
    n = 0;
    while (m_cnt[0] != 7 && n < 20) begin cyc(); n++; end
    async_reset();
    idle(2);

    // Periodic mode with preset 3, then abort
    drive(1, 3, 1, 0); cyc();
    idle(10);
    chk("ar_busy", int'(b1.busy), 1);
    drive(1, 2, 0, 0); cyc();
    chk("ar_abort", int'(b1.busy), 0);
    idle(2);

    // Random traffic
    for (int k = 0; k < 1500; k++) begin
      drive(($urandom_range(15) == 0), $urandom_range(15),
            ($urandom_range(3) == 0), ($urandom_range(4) == 0));
      if ($urandom_range(299) == 0) async_reset();
      else cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
